// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, iteration count, FSM states and operand signedness helpers.
package muldiv_unit_pkg;

  localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
  localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

  localparam int MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_MUL  = 2'd1,
    MD_ST_DIV  = 2'd2,
    MD_ST_FIN  = 2'd3
  } md_state_e;

  function automatic logic op_signed_a(input logic [2:0] op);
    case (op)
      MULDIV_OP_MULHU, MULDIV_OP_DIVU, MULDIV_OP_REMU: return 1'b0;
      default:                                         return 1'b1;
    endcase
  endfunction

  // MULHSU treats rs2 as unsigned even though rs1 is signed
  function automatic logic op_signed_b(input logic [2:0] op);
    case (op)
      MULDIV_OP_MULHSU, MULDIV_OP_MULHU, MULDIV_OP_DIVU, MULDIV_OP_REMU: return 1'b0;
      default:                                                           return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits and record the quotient bit.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // partial remainder is always below the divisor, so the borrow is the top bit
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[XLEN]) begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide responder shared by both harts: accepts one
// tagged request at a time and returns a single-cycle done pulse with the result.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int HART_ID_W  = 1,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  muldiv_start,
  input  logic [2:0]            muldiv_op,
  input  logic [XLEN-1:0]       muldiv_a,
  input  logic [XLEN-1:0]       muldiv_b,
  input  logic [HART_ID_W-1:0]  muldiv_hart_id,
  input  logic [REG_ADDR_W-1:0] muldiv_rd,
  output logic                  muldiv_busy,
  output logic                  muldiv_done,
  output logic [XLEN-1:0]       muldiv_result,
  output logic [HART_ID_W-1:0]  muldiv_done_hart_id,
  output logic [REG_ADDR_W-1:0] muldiv_done_rd
);

  localparam logic [5:0] LAST_ITER = 6'(MULDIV_ITERS - 1);

  md_state_e state, state_next;

  logic [2*XLEN-1:0]     acc, mul_next, mul_full;
  logic [XLEN-1:0]       opnd, div_rem_next, div_quo_next, quo_fix, rem_fix, fin_sel;
  logic [XLEN-1:0]       mag_a, mag_b;
  logic [XLEN:0]         mul_sum;
  logic [2:0]            op;
  logic                  neg;
  logic [5:0]            cnt;
  logic [HART_ID_W-1:0]  hart;
  logic [REG_ADDR_W-1:0] rd;
  logic                  accept, sa, sb, is_div, div_zero, div_ovf, special;

  // incoming request decode: magnitudes and the cases that skip iteration
  always_comb begin
    accept   = muldiv_start & ~muldiv_busy;
    sa       = op_signed_a(muldiv_op) & muldiv_a[XLEN-1];
    sb       = op_signed_b(muldiv_op) & muldiv_b[XLEN-1];
    mag_a    = sa ? -muldiv_a : muldiv_a;
    mag_b    = sb ? -muldiv_b : muldiv_b;
    is_div   = muldiv_op[2];
    div_zero = is_div && (muldiv_b == {XLEN{1'b0}});
    div_ovf  = ((muldiv_op == MULDIV_OP_DIV) || (muldiv_op == MULDIV_OP_REM)) &&
               (muldiv_a == {1'b1, {(XLEN-1){1'b0}}}) && (muldiv_b == {XLEN{1'b1}});
    special  = div_zero | div_ovf;
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      MD_ST_IDLE: begin
        if (!accept)      state_next = MD_ST_IDLE;
        else if (special) state_next = MD_ST_FIN;
        else if (is_div)  state_next = MD_ST_DIV;
        else              state_next = MD_ST_MUL;
      end
      MD_ST_MUL: state_next = (cnt == LAST_ITER) ? MD_ST_FIN : MD_ST_MUL;
      MD_ST_DIV: state_next = (cnt == LAST_ITER) ? MD_ST_FIN : MD_ST_DIV;
      MD_ST_FIN: state_next = MD_ST_IDLE;
      default:   state_next = MD_ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= MD_ST_IDLE;
    else        state <= state_next;
  end

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (acc[2*XLEN-1:XLEN]),
    .quo      (acc[XLEN-1:0]),
    .divisor  (opnd),
    .rem_next (div_rem_next),
    .quo_next (div_quo_next)
  );

  // shift-add step and final sign fixup / word select
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc[XLEN-1:1]};
    mul_full = neg ? -acc : acc;
    quo_fix  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      MULDIV_OP_MUL:                                     fin_sel = mul_full[XLEN-1:0];
      MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_MULHU: fin_sel = mul_full[2*XLEN-1:XLEN];
      MULDIV_OP_DIV, MULDIV_OP_DIVU:                     fin_sel = quo_fix;
      MULDIV_OP_REM, MULDIV_OP_REMU:                     fin_sel = rem_fix;
      default:                                           fin_sel = {XLEN{1'b0}};
    endcase
  end

  // operand capture, iteration and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc                 <= '0;
      opnd                <= '0;
      op                  <= 3'b000;
      neg                 <= 1'b0;
      cnt                 <= 6'd0;
      hart                <= '0;
      rd                  <= '0;
      muldiv_busy         <= 1'b0;
      muldiv_done         <= 1'b0;
      muldiv_result       <= '0;
      muldiv_done_hart_id <= '0;
      muldiv_done_rd      <= '0;
    end else begin
      muldiv_busy <= (state_next != MD_ST_IDLE);
      muldiv_done <= (state == MD_ST_FIN);
      case (state)
        MD_ST_IDLE: begin
          if (accept) begin
            op   <= muldiv_op;
            hart <= muldiv_hart_id;
            rd   <= muldiv_rd;
            cnt  <= 6'd0;
            // special cases park the final {rem, quo} directly with no fixup
            if (special) begin
              acc  <= {(div_zero ? muldiv_a : {XLEN{1'b0}}),
                       (div_zero ? {XLEN{1'b1}} : muldiv_a)};
              opnd <= '0;
              neg  <= 1'b0;
            end else if (is_div) begin
              acc  <= {{XLEN{1'b0}}, mag_a};
              opnd <= mag_b;
              neg  <= muldiv_op[1] ? sa : (sa ^ sb);
            end else begin
              acc  <= {{XLEN{1'b0}}, mag_b};
              opnd <= mag_a;
              neg  <= sa ^ sb;
            end
          end
        end
        MD_ST_MUL: begin
          acc <= mul_next;
          cnt <= cnt + 6'd1;
        end
        MD_ST_DIV: begin
          acc <= {div_rem_next, div_quo_next};
          cnt <= cnt + 6'd1;
        end
        MD_ST_FIN: begin
          muldiv_result       <= fin_sel;
          muldiv_done_hart_id <= hart;
          muldiv_done_rd      <= rd;
        end
        default: begin
          cnt <= 6'd0;
        end
      endcase
    end
  end

endmodule
